// File: rtl/uart_tx_ctrl_if.sv
// Host-side handshake bundle for the UART transmit framer.
// master: host logic that requests frames; slave: the framer itself.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 serial_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  serial_out,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output serial_out,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit framer: start bit, LSB-first data, optional parity,
// one or two stop bits, each bit held CLKS_PER_BIT clocks.
// All outputs are registered; no combinational input-to-output path.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  localparam int unsigned TW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW  = $clog2(DATA_BITS);
  localparam logic        ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tc;

  assign tc = (timer_q == TW'(CLKS_PER_BIT - 1));

  // Next-state, bit timing and data path; outputs are decoded from the
  // next state so that they appear registered in the cycle after each edge.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    serial_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      timer_d = tc ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (bus.tx_start) begin
          state_d  = START;
          shift_d  = bus.tx_data;
          parity_d = (^bus.tx_data) ^ ODD;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tc) begin
          shift_d = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (tc) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = parity_d;
      default: serial_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  // State, data path and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (no parity, even parity, odd
// parity) checked every cycle against a frame-timing model, plus
// hand-computed waveform expectations.
module tb_uart_tx_ctrl;

  localparam int CLKS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(8)) b0 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) b1 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) b2 ();

  uart_tx_ctrl #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  uart_tx_ctrl #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  uart_tx_ctrl #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // {serial_out, tx_busy, tx_done} of instance k
  function automatic logic [2:0] get_out(int k);
    case (k)
      0:       return {b0.serial_out, b0.tx_busy, b0.tx_done};
      1:       return {b1.serial_out, b1.tx_busy, b1.tx_done};
      default: return {b2.serial_out, b2.tx_busy, b2.tx_done};
    endcase
  endfunction

  function automatic logic start_of(int k);
    case (k)
      0:       return b0.tx_start;
      1:       return b1.tx_start;
      default: return b2.tx_start;
    endcase
  endfunction

  function automatic logic [7:0] data_of(int k);
    case (k)
      0:       return b0.tx_data;
      1:       return b1.tx_data;
      default: return b2.tx_data;
    endcase
  endfunction

  task automatic set_in(int k, logic s, logic [7:0] d);
    case (k)
      0:       begin b0.tx_start = s; b0.tx_data = d; end
      1:       begin b1.tx_start = s; b1.tx_data = d; end
      default: begin b2.tx_start = s; b2.tx_data = d; end
    endcase
  endtask

  // Model: a frame is a list of bits laid out in time from its first busy
  // cycle; the expected outputs follow from the cycle offset alone.
  int unsigned cyc = 0;
  int          fstart [3];
  logic [7:0]  fdata  [3];
  bit          factive[3];

  function automatic int par_en(int k);
    return (k != 0) ? 1 : 0;
  endfunction

  function automatic logic [2:0] expected(int k, int t);
    int   nbits, len, o, b;
    logic p;
    nbits = 1 + 8 + par_en(k) + 1;
    len   = nbits * CLKS;
    if (!factive[k] || t < fstart[k]) return 3'b100;
    o = t - fstart[k];
    if (o > len)  return 3'b100;
    if (o == len) return 3'b101;
    b = o / CLKS;
    p = (^fdata[k]) ^ (k == 2);
    if (b == 0) return 3'b010;
    if (b <= 8) return {fdata[k][b-1], 2'b10};
    if (par_en(k) == 1 && b == 9) return {p, 2'b10};
    return 3'b110;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model update: accept a start whenever the model says the line is not busy.
  always @(posedge clk or posedge rst) begin
    logic [2:0] e;
    if (rst) begin
      for (int k = 0; k < 3; k++) factive[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        e = expected(k, int'(cyc));
        if (start_of(k) && !e[1]) begin
          factive[k] = 1'b1;
          fstart[k]  = int'(cyc) + 1;
          fdata[k]   = data_of(k);
        end
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d outputs cycle %0d", k, cyc), int'(get_out(k)), int'(expected(k, int'(cyc))));
    end
  end

  task automatic send(int k, logic [7:0] d);
    @(negedge clk);
    set_in(k, 1'b1, d);
    @(negedge clk);
    set_in(k, 1'b0, d);
  endtask

  // Called at the negedge of the first busy cycle; samples the middle of
  // each bit period, counts busy cycles and finds the done pulse.
  task automatic capture(int k, output logic [10:0] bits, output int busy_n, output int done_at);
    logic [2:0] a;
    bits    = '0;
    busy_n  = 0;
    done_at = -1;
    for (int i = 1; i <= 300; i++) begin
      a = get_out(k);
      if (a[1]) busy_n++;
      if ((i - 1) % CLKS == CLKS / 2 && (i - 1) / CLKS < 11) bits[(i - 1) / CLKS] = a[2];
      if (a[0]) begin
        done_at = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [10:0] bits;
    int          busy_n, done_at;
    int          busy_total, done_cnt, first_done, second_done;
    logic [2:0]  a;
    logic        s100, b101, s102;

    for (int k = 0; k < 3; k++) set_in(k, 1'b0, 8'h00);

    // Reset, then idle
    repeat (3) @(negedge clk);
    check("reset state dut0", int'(get_out(0)), 3'b100);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      a = get_out(0);
      if (a != 3'b100) done_cnt++;
    end
    check("idle non-idle cycles", done_cnt, 0);

    // Basic frame 0xA5
    send(0, 8'hA5);
    capture(0, bits, busy_n, done_at);
    check("basic bits", int'(bits[9:0]), 10'b1101001010);
    check("basic busy cycles", busy_n, 100);
    check("basic done cycle", done_at, 101);
    repeat (5) @(negedge clk);

    // Even parity
    send(1, 8'hA5);
    capture(1, bits, busy_n, done_at);
    check("even parity bit", int'(bits[9]), 0);
    check("even data+start", int'(bits[8:0]), 9'b101001010);
    check("even stop bit", int'(bits[10]), 1);
    check("even busy cycles", busy_n, 110);
    check("even done cycle", done_at, 111);
    repeat (5) @(negedge clk);

    // Odd parity
    send(2, 8'hA5);
    capture(2, bits, busy_n, done_at);
    check("odd parity bit", int'(bits[9]), 1);
    check("odd busy cycles", busy_n, 110);
    check("odd done cycle", done_at, 111);
    repeat (5) @(negedge clk);

    // Ignored start with changed data mid-frame
    send(0, 8'hA5);
    fork
      capture(0, bits, busy_n, done_at);
      begin
        repeat (29) @(negedge clk);
        set_in(0, 1'b1, 8'h3C);
        @(negedge clk);
        set_in(0, 1'b0, 8'h3C);
      end
    join
    check("ignored-start bits", int'(bits[9:0]), 10'b1101001010);
    check("ignored-start busy cycles", busy_n, 100);
    check("ignored-start done cycle", done_at, 101);
    busy_total = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      a = get_out(0);
      busy_total += int'(a[1]);
    end
    check("no second frame", busy_total, 0);

    // Back-to-back 0x00 then 0xFF, second start in the done cycle
    send(0, 8'h00);
    busy_total  = 0;
    done_cnt    = 0;
    first_done  = -1;
    second_done = -1;
    s100 = 1'bx; b101 = 1'bx; s102 = 1'bx;
    for (int i = 1; i <= 230; i++) begin
      a = get_out(0);
      busy_total += int'(a[1]);
      if (i == 100) s100 = a[2];
      if (i == 101) b101 = a[1];
      if (i == 102) s102 = a[2];
      if (a[0]) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = i;
          set_in(0, 1'b1, 8'hFF);
        end else begin
          second_done = i;
        end
      end else begin
        set_in(0, 1'b0, 8'hFF);
      end
      @(negedge clk);
    end
    check("b2b busy total", busy_total, 200);
    check("b2b done pulses", done_cnt, 2);
    check("b2b first done", first_done, 101);
    check("b2b second done", second_done, 202);
    check("b2b last stop cycle", int'(s100), 1);
    check("b2b busy drop", int'(b101), 0);
    check("b2b second start bit", int'(s102), 0);

    // Reset mid-frame
    send(0, 8'h55);
    repeat (44) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid reset serial", int'(b0.serial_out), 1);
    check("mid reset busy", int'(b0.tx_busy), 0);
    check("mid reset done", int'(b0.tx_done), 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = get_out(0);
      done_cnt += int'(a[0]) + int'(a[1]);
    end
    check("post reset quiet", done_cnt, 0);
    send(0, 8'h0F);
    capture(0, bits, busy_n, done_at);
    check("post reset bits", int'(bits[9:0]), 10'b1000011110);
    check("post reset busy cycles", busy_n, 100);
    check("post reset done cycle", done_at, 101);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
